dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined ARM core: services the MEM-stage `MemRead`/`MemWrite` requests issued by the control unit, with a configurable multi-cycle access latency. While an access is in flight it drives a stall request into the hazard unit (`stallIF`/`stallID`/`flushEX` path). It holds the word-addressed data RAM plus two memory-mapped registers: an LED output latch and a free-running cycle counter.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; byte addresses `0 .. DEPTH*4-1` are RAM.
- `LATENCY`, 2: wait cycles per access; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_MemRead`  in  1  read request from the MEM stage.
- `i_MemWrite`  in  1  write request from the MEM stage.
- `i_Addr`  in  32  byte address.
- `i_WData`  in  32  store data.
- `o_RData`  out  32  load data; valid only while `o_Ready`=1.
- `o_Ready`  out  1  access complete this cycle.
- `o_Stall`  out  1  combinational; MEM stage and all earlier stages hold.
- `o_AddrErr`  out  1  access faulted; valid only while `o_Ready`=1.
- `o_LED`  out  8  MMIO LED latch.

## Operation
- **FSM states:** IDLE, WAIT, DONE. A 4-bit down-counter `cnt` times the WAIT state.
- **IDLE:**
  - With `i_MemRead|i_MemWrite`=1, latch `i_Addr`, `i_WData` and op, load `cnt`=LATENCY-1, and go to WAIT.
  - Op is write if `i_MemWrite`=1, otherwise read.
  - Both request bits high is a write and sets the error flag.
- **WAIT:** if `cnt`=0, perform the access and go to DONE; otherwise decrement `cnt`.
- **DONE:** `o_Ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- **`o_Stall`** = (`i_MemRead|i_MemWrite`) && state≠DONE.
- **Access decode** uses the latched address, evaluated at the WAIT→DONE edge:
  - `addr[1:0]`≠0: error. No RAM or MMIO effect; `o_RData`=0.
  - `addr` < DEPTH*4: RAM word `addr[31:2]`. A read loads `o_RData`; a write commits the RAM word on this edge.
  - `0xFFFF_0000` (LED): a write sets `o_LED`=`wdata[7:0]`; a read returns {24'b0, `o_LED`}.
  - `0xFFFF_0004` (cycle counter): a read returns the counter value. A write is ignored and is not an error.
  - Any other address: error, `o_RData`=0.
- **Error reporting:** `o_AddrErr` is registered with `o_RData` and is cleared on DONE→IDLE.
- **Request changes during WAIT:** the latched request completes unchanged; request inputs are not re-sampled until IDLE.
- **Cycle counter:** 32-bit, increments every cycle from 0 after reset and wraps from `0xFFFF_FFFF` to 0. A read returns the value sampled at the access edge.

## Timing
- **Reset (asynchronous, `reset`=0):**
  - FSM goes to IDLE and `cnt`=0.
  - Outputs: `o_RData`=0, `o_Ready`=0, `o_AddrErr`=0, `o_LED`=0; cycle counter=0.
  - RAM contents are not cleared.
- **Reset mid-access:** the pending write is dropped, the RAM is not modified, and the FSM restarts in IDLE on release.
- **Request cycle numbering** (request first visible in IDLE at cycle 0):
  - Cycles 1..LATENCY are WAIT.
  - Cycle LATENCY+1 is DONE: `o_Ready`=1, `o_Stall`=0.
  - `o_Stall`=1 in cycles 0..LATENCY.
  - Total access occupancy: LATENCY+2 cycles, including the DONE cycle.
- **Back-to-back accesses:** the next request is seen in IDLE in cycle LATENCY+2. The minimum request-to-request spacing is LATENCY+2 cycles.
- **Write visibility:** a write is visible to a read whose WAIT→DONE edge is later than the write's.
- **Idle with no request:** `o_Stall`=0 and `o_Ready`=0.

## Test plan
- **Reset values:** hold `reset`=0, then release → `o_LED`=0, `o_Ready`=0, `o_Stall`=0; a counter read immediately after reset returns a value ≤ LATENCY+1.
- **Write then read, LATENCY=2:**
  - Stimulus: write `0xDEADBEEF` to `0x10`, then read `0x10`.
  - `o_Stall`=1 for 3 cycles per access; `o_Ready` in cycle 3.
  - Read returns `0xDEADBEEF`, `o_AddrErr`=0.
- **Faulting accesses:**
  - Read of `0x13` (misaligned) → `o_AddrErr`=1, `o_RData`=0.
  - Read of DEPTH*4 → `o_AddrErr`=1.
  - Write with both request bits high → `o_AddrErr`=1.
- **MMIO:**
  - Write `0x1A5` to `0xFFFF_0000` → `o_LED`=`0xA5`; a read of `0xFFFF_0000` returns `0x000000A5`.
  - A write to `0xFFFF_0004` gives no error, and two counter reads differ by exactly the cycles between their access edges.
- **Reset mid-access:** assert `reset` during WAIT of a write of `0x12345678` to `0x20` → after release, a read of `0x20` returns the prior contents; `o_Ready` never pulses for the aborted access.
- **Request instability and LATENCY=1:** deassert `i_MemRead` during WAIT → the access still completes with `o_Ready` in cycle LATENCY+1; with LATENCY=1, `o_Ready` is in cycle 2.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Multi-cycle RAM access plus LED latch and cycle-counter MMIO.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WData,
  output logic [31:0] o_RData,
  output logic        o_Ready,
  output logic        o_Stall,
  output logic        o_AddrErr,
  output logic [7:0]  o_LED
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] RAM_TOP  = 32'(DEPTH * 4);
  localparam logic [31:0] LED_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] CYC_ADDR = 32'hFFFF_0004;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        both_q;
  logic [31:0] cyc;
  logic [31:0] ram [DEPTH];

  logic          req;
  logic          access;
  logic          mis;
  logic          ram_hit;
  logic          led_hit;
  logic          cyc_hit;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [31:0]   rdata_n;

  assign req     = i_MemRead | i_MemWrite;
  assign access  = (state == WAIT) && (cnt == 4'd0);
  assign mis     = |addr_q[1:0];
  assign ram_hit = !mis && (addr_q < RAM_TOP);
  assign led_hit = !mis && (addr_q == LED_ADDR);
  assign cyc_hit = !mis && (addr_q == CYC_ADDR);
  assign acc_err = both_q || !(ram_hit || led_hit || cyc_hit);
  assign idx     = addr_q[AW+1:2];

  assign o_Ready = (state == DONE);
  assign o_Stall = req && (state != DONE);

  always_comb begin
    rdata_n = '0;
    if (!we_q) begin
      unique case (1'b1)
        ram_hit: rdata_n = ram[idx];
        led_hit: rdata_n = {24'b0, o_LED};
        cyc_hit: rdata_n = cyc;
        default: rdata_n = '0;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_n = WAIT;
          cnt_n   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = DONE;
        else             cnt_n   = cnt - 4'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Request is captured once; later input changes are ignored until IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      both_q  <= 1'b0;
    end else if (state == IDLE && req) begin
      addr_q  <= i_Addr;
      wdata_q <= i_WData;
      we_q    <= i_MemWrite;
      both_q  <= i_MemRead & i_MemWrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_RData   <= '0;
      o_AddrErr <= 1'b0;
      o_LED     <= '0;
      cyc       <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (access) begin
        o_RData   <= rdata_n;
        o_AddrErr <= acc_err;
        if (we_q && led_hit) o_LED <= wdata_q[7:0];
      end else if (state == DONE) begin
        o_AddrErr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && we_q && ram_hit) ram[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scoreboard of expected responses
// plus per-scenario timing checks on LATENCY=2 and LATENCY=1 instances.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_MemRead, i_MemWrite;
  logic [31:0] i_Addr, i_WData;
  logic [31:0] o_RData;
  logic        o_Ready, o_Stall, o_AddrErr;
  logic [7:0]  o_LED;

  logic        r1, w1;
  logic [31:0] a1, d1;
  logic [31:0] rd1;
  logic        ry1, st1, er1;
  logic [7:0]  led1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_Addr(i_Addr), .i_WData(i_WData),
    .o_RData(o_RData), .o_Ready(o_Ready), .o_Stall(o_Stall),
    .o_AddrErr(o_AddrErr), .o_LED(o_LED)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_MemRead(r1), .i_MemWrite(w1),
    .i_Addr(a1), .i_WData(d1),
    .o_RData(rd1), .o_Ready(ry1), .o_Stall(st1),
    .o_AddrErr(er1), .o_LED(led1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t sb[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int tick = 0;
  int last_tick;
  logic [31:0] last_rdata;

  always @(posedge clk) tick++;

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (o_Ready === 1'b1) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ready rdata=%h err=%b", o_RData, o_AddrErr);
      end else begin
        e = sb.pop_front();
        if (o_AddrErr !== e.err || (e.chk && o_RData !== e.rdata))
          $display("FAIL response got rdata=%h err=%b want rdata=%h err=%b chk=%b",
                   o_RData, o_AddrErr, e.rdata, e.err, e.chk);
        else
          pass_cnt++;
      end
    end
  end

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic chk, input int drop_at,
                        output int stalls, output int rcyc);
    sb.push_back('{rdata: exp_rd, err: exp_err, chk: chk});
    @(negedge clk);
    i_MemRead = rd; i_MemWrite = wr; i_Addr = addr; i_WData = wdata;
    stalls = 0;
    rcyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == drop_at) begin
        i_MemRead = 1'b0; i_MemWrite = 1'b0;
      end
      #1;
      if (o_Stall) stalls++;
      if (o_Ready) begin
        rcyc = c;
        last_rdata = o_RData;
        last_tick = tick;
        break;
      end
      @(negedge clk);
    end
    i_MemRead = 1'b0; i_MemWrite = 1'b0;
    if (rcyc < 0) begin
      total_cnt++;
      $display("FAIL timeout addr=%h got no ready want ready", addr);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic access1(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int rcyc, output logic [31:0] rdata,
                         output logic err);
    @(negedge clk);
    r1 = rd; w1 = wr; a1 = addr; d1 = wdata;
    rcyc = -1; rdata = '0; err = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ry1) begin
        rcyc = c; rdata = rd1; err = er1;
        break;
      end
      @(negedge clk);
    end
    r1 = 1'b0; w1 = 1'b0;
  endtask

  task automatic test_reset();
    int s, rc;
    reset = 1'b0;
    i_MemRead = 0; i_MemWrite = 0; i_Addr = '0; i_WData = '0;
    r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (o_LED !== 8'h00) $display("FAIL reset_led got %h want 00", o_LED);
    else pass_cnt++;
    total_cnt++;
    if (o_Ready !== 1'b0) $display("FAIL reset_ready got %b want 0", o_Ready);
    else pass_cnt++;
    total_cnt++;
    if (o_Stall !== 1'b0) $display("FAIL reset_stall got %b want 0", o_Stall);
    else pass_cnt++;
    total_cnt++;
    if (o_AddrErr !== 1'b0 || o_RData !== 32'h0)
      $display("FAIL reset_rdata got %h/%b want 0/0", o_RData, o_AddrErr);
    else pass_cnt++;
    @(posedge clk);
    #2 reset = 1'b1;
    access(1, 0, 32'hFFFF_0004, 0, 0, 0, 0, -1, s, rc);
    total_cnt++;
    if (last_rdata > 32'(LAT + 1))
      $display("FAIL reset_counter got %0d want <= %0d", last_rdata, LAT + 1);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int s, rc;
    access(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, -1, s, rc);
    total_cnt++;
    if (s != LAT + 1 || rc != LAT + 1)
      $display("FAIL wr_timing got stall=%0d ready=%0d want %0d/%0d", s, rc, LAT + 1, LAT + 1);
    else pass_cnt++;
    access(0, 1, 32'h14, 32'h5555_AAAA, 0, 0, 0, -1, s, rc);
    access(0, 1, 32'hFFC, 32'h0F0F_0F0F, 0, 0, 0, -1, s, rc);
    access(1, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 1, -1, s, rc);
    total_cnt++;
    if (s != LAT + 1 || rc != LAT + 1)
      $display("FAIL rd_timing got stall=%0d ready=%0d want %0d/%0d", s, rc, LAT + 1, LAT + 1);
    else pass_cnt++;
    access(1, 0, 32'h14, 0, 32'h5555_AAAA, 0, 1, -1, s, rc);
    access(1, 0, 32'hFFC, 0, 32'h0F0F_0F0F, 0, 1, -1, s, rc);
  endtask

  task automatic test_faults();
    int s, rc;
    access(1, 0, 32'h13, 0, 32'h0, 1, 1, -1, s, rc);
    @(negedge clk);
    #1;
    total_cnt++;
    if (o_AddrErr !== 1'b0 || o_Ready !== 1'b0)
      $display("FAIL err_clear got err=%b ready=%b want 0/0", o_AddrErr, o_Ready);
    else pass_cnt++;
    access(1, 0, 32'(1024 * 4), 0, 32'h0, 1, 1, -1, s, rc);
    access(1, 1, 32'h18, 32'h1, 0, 1, 0, -1, s, rc);
    access(1, 0, 32'h8000_0000, 0, 32'h0, 1, 1, -1, s, rc);
  endtask

  task automatic test_mmio();
    int s, rc;
    access(0, 1, 32'hFFFF_0000, 32'h1A5, 0, 0, 0, -1, s, rc);
    total_cnt++;
    if (o_LED !== 8'hA5) $display("FAIL led_write got %h want a5", o_LED);
    else pass_cnt++;
    access(1, 0, 32'hFFFF_0000, 0, 32'h0000_00A5, 0, 1, -1, s, rc);
    access(0, 1, 32'hFFFF_0004, 32'h1234, 0, 0, 0, -1, s, rc);
  endtask

  task automatic test_back_to_back();
    int s, rc, t1, t2, t3;
    logic [31:0] c1, c2, c3;
    access(1, 0, 32'hFFFF_0004, 0, 0, 0, 0, -1, s, rc);
    c1 = last_rdata; t1 = last_tick;
    access(1, 0, 32'hFFFF_0004, 0, 0, 0, 0, -1, s, rc);
    c2 = last_rdata; t2 = last_tick;
    total_cnt++;
    if (c2 - c1 != 32'(LAT + 2) || t2 - t1 != LAT + 2)
      $display("FAIL b2b_spacing got cnt=%0d ticks=%0d want %0d", c2 - c1, t2 - t1, LAT + 2);
    else pass_cnt++;
    repeat (7) @(negedge clk);
    access(1, 0, 32'hFFFF_0004, 0, 0, 0, 0, -1, s, rc);
    c3 = last_rdata; t3 = last_tick;
    total_cnt++;
    if (c3 - c2 != 32'(t3 - t2))
      $display("FAIL counter_delta got %0d want %0d", c3 - c2, t3 - t2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int s, rc;
    logic seen;
    access(0, 1, 32'h20, 32'h0BAD_F00D, 0, 0, 0, -1, s, rc);
    @(negedge clk);
    i_MemWrite = 1'b1; i_Addr = 32'h20; i_WData = 32'h1234_5678;
    @(negedge clk);
    #1 reset = 1'b0;
    i_MemWrite = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #3 seen = seen | o_Ready;
    end
    total_cnt++;
    if (o_LED !== 8'h00) $display("FAIL mid_reset_led got %h want 00", o_LED);
    else pass_cnt++;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #3 seen = seen | o_Ready;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_ready got 1 want 0");
    else pass_cnt++;
    access(1, 0, 32'h20, 0, 32'h0BAD_F00D, 0, 1, -1, s, rc);
  endtask

  task automatic test_unstable();
    int s, rc;
    access(1, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 1, 2, s, rc);
    total_cnt++;
    if (rc != LAT + 1 || s != 2)
      $display("FAIL unstable got ready=%0d stall=%0d want %0d/2", rc, s, LAT + 1);
    else pass_cnt++;
  endtask

  task automatic test_latency1();
    int rc;
    logic [31:0] rd;
    logic er;
    access1(0, 1, 32'h40, 32'hCAFE_F00D, rc, rd, er);
    total_cnt++;
    if (rc != 2 || er !== 1'b0)
      $display("FAIL lat1_write got ready=%0d err=%b want 2/0", rc, er);
    else pass_cnt++;
    access1(1, 0, 32'h40, 0, rc, rd, er);
    total_cnt++;
    if (rc != 2 || rd !== 32'hCAFE_F00D || er !== 1'b0)
      $display("FAIL lat1_read got ready=%0d rdata=%h err=%b want 2/cafef00d/0", rc, rd, er);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_faults();
    test_mmio();
    test_back_to_back();
    test_reset_mid();
    test_unstable();
    test_latency1();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
